// File: rtl/quick_rs232_rx_if.sv
// quick_rs232_rx_if: byte handshake and status bundle between the RS-232 receiver and its consumer
interface quick_rs232_rx_if #(
  parameter int BYTE_LEN = 8
);
  logic [BYTE_LEN-1:0] rx_data;
  logic rx_valid;
  logic rx_ack;
  logic rx_parity_error;
  logic rx_frame_error;
  logic rx_overrun;
  logic rx_busy;
  modport master (
    output rx_data, rx_valid, rx_parity_error, rx_frame_error, rx_overrun, rx_busy,
    input  rx_ack
  );
  modport slave (
    input  rx_data, rx_valid, rx_parity_error, rx_frame_error, rx_overrun, rx_busy,
    output rx_ack
  );
endinterface

// File: rtl/quick_rs232_rx.sv
// quick_rs232_rx: RS-232 frame receiver with valid/ack byte hand-off, error pulses and optional CTS
module quick_rs232_rx #(
  parameter int CLK_FREQ             = 50000000,
  parameter int DEFAULT_BYTE_LEN     = 8,
  parameter int DEFAULT_PARITY       = 1,
  parameter int DEFAULT_STOP_BITS    = 0,
  parameter int DEFAULT_BAUD_RATE    = 9600,
  parameter int DEFAULT_FLOW_CONTROL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic             cts,
  quick_rs232_rx_if.master rx_if
);
  localparam int BL = DEFAULT_BYTE_LEN;
  localparam logic [31:0] TICKS = 32'(CLK_FREQ / DEFAULT_BAUD_RATE);
  localparam logic [31:0] HALF = TICKS / 32'd2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  if (DEFAULT_BYTE_LEN < 5 || DEFAULT_BYTE_LEN > 9 || DEFAULT_PARITY < 0 || DEFAULT_PARITY > 4 ||
      DEFAULT_STOP_BITS < 0 || DEFAULT_STOP_BITS > 2 || DEFAULT_FLOW_CONTROL < 0 ||
      DEFAULT_FLOW_CONTROL > 1 || CLK_FREQ < 2 * DEFAULT_BAUD_RATE) begin : g_bad_cfg
    $error("quick_rs232_rx: unsupported parameter set");
  end
  state_t state_q, state_d;
  logic rx_m_q, rx_s_q;
  logic armed_q, armed_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [BL-1:0] sh_q, sh_d, data_q, data_d;
  logic par_ok_q, par_ok_d, stop_q, stop_d;
  logic valid_q, valid_d, cts_q, cts_d;
  logic pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
  logic tick_end, half_end, par_exp;
  assign tick_end = cnt_q == TICKS - 32'd1;
  assign half_end = cnt_q == HALF - 32'd1;
  assign par_exp = DEFAULT_PARITY == 1 ? ^sh_q : DEFAULT_PARITY == 2 ? ~^sh_q : DEFAULT_PARITY == 3;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      data_q   <= '0;
      par_ok_q <= 1'b1;
      stop_q   <= 1'b1;
      valid_q  <= 1'b0;
      cts_q    <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      rx_m_q   <= rx;
      rx_s_q   <= rx_m_q;
      state_q  <= state_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      data_q   <= data_d;
      par_ok_q <= par_ok_d;
      stop_q   <= stop_d;
      valid_q  <= valid_d;
      cts_q    <= cts_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
    end
  end
  // Arming needs the line seen high in IDLE, so a held-low line after a bad stop bit cannot restart a frame
  always_comb begin
    state_d  = state_q;
    armed_d  = state_q == IDLE && (armed_q || rx_s_q);
    cnt_d    = cnt_q + 32'd1;
    bit_d    = bit_q;
    sh_d     = sh_q;
    data_d   = data_q;
    par_ok_d = par_ok_q;
    stop_d   = stop_q;
    valid_d  = valid_q & ~rx_if.rx_ack;
    pe_d     = 1'b0;
    fe_d     = 1'b0;
    ov_d     = 1'b0;
    case (state_q)
      IDLE: if (armed_q && !rx_s_q) begin
        state_d = START;
        cnt_d   = '0;
      end
      START: if (half_end) begin
        state_d  = rx_s_q ? IDLE : DATA;
        cnt_d    = '0;
        bit_d    = '0;
        par_ok_d = 1'b1;
      end
      DATA: if (tick_end) begin
        cnt_d = '0;
        sh_d  = {rx_s_q, sh_q[BL-1:1]};
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'(BL - 1)) state_d = DEFAULT_PARITY == 0 ? STOP : PARITY;
      end
      PARITY: if (tick_end) begin
        cnt_d    = '0;
        par_ok_d = rx_s_q == par_exp;
        state_d  = STOP;
      end
      STOP: if (tick_end) begin
        cnt_d   = '0;
        stop_d  = rx_s_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        fe_d    = !stop_q;
        pe_d    = stop_q && !par_ok_q;
        if (stop_q && par_ok_q) begin
          if (!valid_q || rx_if.rx_ack) begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end else begin
            ov_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    cts_d = DEFAULT_FLOW_CONTROL != 0 ? ~valid_d : 1'b1;
  end
  assign cts                   = cts_q;
  assign rx_if.rx_data         = data_q;
  assign rx_if.rx_valid        = valid_q;
  assign rx_if.rx_parity_error = pe_q;
  assign rx_if.rx_frame_error  = fe_q;
  assign rx_if.rx_overrun      = ov_q;
  assign rx_if.rx_busy         = state_q != IDLE;
endmodule

// File: tb/tb_quick_rs232_rx.sv
// tb_quick_rs232_rx: vector table, corner sequences and random frames vs. a frame-level outcome model
module tb_quick_rs232_rx;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, ack = 1'b0;
  logic cts0, cts1;
  int checks = 0, errors = 0;
  int pe_tot = 0, fe_tot = 0, ov_tot = 0, busy_tot = 0;
  int pe0, fe0, ov0, b0;
  quick_rs232_rx_if #(.BYTE_LEN(8)) if0 ();
  quick_rs232_rx_if #(.BYTE_LEN(8)) if1 ();
  assign if0.rx_ack = ack;
  assign if1.rx_ack = ack;
  quick_rs232_rx #(.CLK_FREQ(1000000), .DEFAULT_BYTE_LEN(8), .DEFAULT_PARITY(1), .DEFAULT_STOP_BITS(0),
    .DEFAULT_BAUD_RATE(100000), .DEFAULT_FLOW_CONTROL(0))
    dut0 (.clk(clk), .rst(rst), .rx(rx), .cts(cts0), .rx_if(if0.master));
  quick_rs232_rx #(.CLK_FREQ(1000000), .DEFAULT_BYTE_LEN(8), .DEFAULT_PARITY(1), .DEFAULT_STOP_BITS(0),
    .DEFAULT_BAUD_RATE(100000), .DEFAULT_FLOW_CONTROL(1))
    dut1 (.clk(clk), .rst(rst), .rx(rx), .cts(cts1), .rx_if(if1.master));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pe_tot   <= pe_tot + int'(if0.rx_parity_error);
    fe_tot   <= fe_tot + int'(if0.rx_frame_error);
    ov_tot   <= ov_tot + int'(if0.rx_overrun);
    busy_tot <= busy_tot + int'(if0.rx_busy);
  end
  typedef struct {
    logic [7:0] d;
    logic p, s, ack_after;
    int fe, pe, ov;
    logic v;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic snap();
    pe0 = pe_tot; fe0 = fe_tot; ov0 = ov_tot; b0 = busy_tot;
  endtask
  task automatic send(input logic [7:0] d, input logic p, input logic s, input logic release_line);
    rx = 1'b0; cyc(10);
    for (int i = 0; i < 8; i++) begin rx = d[i]; cyc(10); end
    rx = p; cyc(10);
    rx = s; cyc(10);
    if (release_line) rx = 1'b1;
  endtask
  task automatic pulse_ack();
    ack = 1'b1; cyc(1); ack = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [7:0] d, mdata;
    logic pb, sb, mvalid;
    int efe, epe, eov, w;
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b1, 8'hA5};
    tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 0, 1, 0, 1'b0, 8'h00};
    tbl[2] = '{8'h11, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 8'h11};
    tbl[3] = '{8'h22, 1'b0, 1'b1, 1'b1, 0, 0, 1, 1'b1, 8'h11};
    tbl[4] = '{8'h11, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b1, 8'h11};
    tbl[5] = '{8'h22, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 8'h22};
    tbl[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 0, 0, 1, 1'b1, 8'h22};
    tbl[7] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b0, 8'h00};
    tbl[8] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b0, 8'h00};
    tbl[9] = '{8'hFF, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b1, 8'hFF};
    cyc(3);
    chk("rst_data", if0.rx_data, 0);
    chk("rst_valid", if0.rx_valid, 0);
    chk("rst_busy", if0.rx_busy, 0);
    chk("rst_cts0", cts0, 0);
    chk("rst_cts1", cts1, 0);
    chk("rst_err", {if0.rx_parity_error, if0.rx_frame_error, if0.rx_overrun}, 0);
    rst = 1'b0;
    cyc(1);
    chk("rel_cts0", cts0, 1);
    chk("rel_cts1", cts1, 1);
    cyc(3);
    for (int i = 0; i < 10; i++) begin
      snap();
      send(tbl[i].d, tbl[i].p, tbl[i].s, 1'b1);
      cyc(3);
      chk($sformatf("v%0d_fe", i), fe_tot - fe0, tbl[i].fe);
      chk($sformatf("v%0d_pe", i), pe_tot - pe0, tbl[i].pe);
      chk($sformatf("v%0d_ov", i), ov_tot - ov0, tbl[i].ov);
      chk($sformatf("v%0d_valid0", i), if0.rx_valid, tbl[i].v);
      chk($sformatf("v%0d_valid1", i), if1.rx_valid, tbl[i].v);
      chk($sformatf("v%0d_cts0", i), cts0, 1);
      chk($sformatf("v%0d_cts1", i), cts1, !tbl[i].v);
      if (tbl[i].v) begin
        chk($sformatf("v%0d_data0", i), if0.rx_data, tbl[i].ed);
        chk($sformatf("v%0d_data1", i), if1.rx_data, tbl[i].ed);
      end
      if (tbl[i].ack_after) begin
        pulse_ack();
        chk($sformatf("v%0d_ack_valid", i), if0.rx_valid, 0);
        chk($sformatf("v%0d_ack_cts1", i), cts1, 1);
      end
      cyc(3);
    end
    // Bad stop bit followed by a long low line: one error, and no phantom frame from the low level
    snap();
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    cyc(2);
    b0 = busy_tot;
    cyc(28);
    chk("fe_low_busy", busy_tot - b0, 0);
    rx = 1'b1;
    cyc(5);
    chk("fe_low_fe", fe_tot - fe0, 1);
    chk("fe_low_pe", pe_tot - pe0, 0);
    chk("fe_low_valid", if0.rx_valid, 0);
    send(8'h96, 1'b0, 1'b1, 1'b1);
    cyc(3);
    chk("fe_after_valid", if0.rx_valid, 1);
    chk("fe_after_data", if0.rx_data, 8'h96);
    pulse_ack();
    cyc(4);
    snap();
    rx = 1'b0;
    cyc(3);
    chk("glitch_busy", if0.rx_busy, 1);
    rx = 1'b1;
    for (w = 0; w < 8 && if0.rx_busy; w++) cyc(1);
    chk("glitch_idle", if0.rx_busy, 0);
    cyc(3);
    chk("glitch_err", (pe_tot - pe0) + (fe_tot - fe0) + (ov_tot - ov0), 0);
    chk("glitch_valid", if0.rx_valid, 0);
    cyc(3);
    send(8'h5A, 1'b0, 1'b1, 1'b1);
    cyc(3);
    chk("prerst_valid", if1.rx_valid, 1);
    rx = 1'b0; cyc(10);
    for (int i = 0; i < 3; i++) begin rx = 1'b1; cyc(10); end
    rx = 1'b0; cyc(5);
    chk("midfrm_busy", if1.rx_busy, 1);
    rst = 1'b1;
    cyc(1);
    chk("midrst_valid0", if0.rx_valid, 0);
    chk("midrst_busy0", if0.rx_busy, 0);
    chk("midrst_valid1", if1.rx_valid, 0);
    chk("midrst_busy1", if1.rx_busy, 0);
    rst = 1'b0;
    rx = 1'b1;
    cyc(1);
    chk("midrst_cts1", cts1, 1);
    cyc(5);
    mvalid = 1'b0;
    mdata = 8'h00;
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      pb = $urandom_range(0, 3) == 0;
      sb = $urandom_range(0, 5) == 0;
      efe = int'(sb);
      epe = int'(!sb && pb);
      eov = 0;
      if (!sb && !pb) begin
        if (!mvalid) begin
          mvalid = 1'b1;
          mdata = d;
        end else begin
          eov = 1;
        end
      end
      snap();
      send(d, ^d ^ pb, !sb, 1'b1);
      cyc(3);
      chk($sformatf("r%0d_fe", n), fe_tot - fe0, efe);
      chk($sformatf("r%0d_pe", n), pe_tot - pe0, epe);
      chk($sformatf("r%0d_ov", n), ov_tot - ov0, eov);
      chk($sformatf("r%0d_valid", n), if0.rx_valid, mvalid);
      chk($sformatf("r%0d_cts1", n), cts1, !mvalid);
      if (mvalid) chk($sformatf("r%0d_data", n), if0.rx_data, mdata);
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        mvalid = 1'b0;
        chk($sformatf("r%0d_ack", n), if0.rx_valid, 0);
      end
      cyc($urandom_range(3, 7));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
